// File: rtl/ysyx_22041412_mem_arb_pkg.sv
// Shared encodings for the I/D memory arbiter: FSM states and bus owner.
package ysyx_22041412_mem_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_REQ  = 2'd1,
    ARB_RESP = 2'd2
  } arb_state_e;

  typedef enum logic {
    OWNER_I = 1'b0,
    OWNER_D = 1'b1
  } arb_owner_e;

endpackage

// File: rtl/ysyx_22041412_rr2.sv
// Two-way round-robin select: a lone requester wins, a tie goes to the side
// that did not win last time. Purely combinational, one-hot grant.
module ysyx_22041412_rr2
  import ysyx_22041412_mem_arb_pkg::*;
(
  input  logic [1:0] req_i,
  input  arb_owner_e last_i,
  output logic [1:0] gnt_o
);

  always_comb begin
    gnt_o = 2'b00;
    case (req_i)
      2'b01:   gnt_o = 2'b01;
      2'b10:   gnt_o = 2'b10;
      2'b11:   gnt_o = (last_i == OWNER_D) ? 2'b01 : 2'b10;
      default: gnt_o = 2'b00;
    endcase
  end

endmodule

// File: rtl/ysyx_22041412_mem_arb.sv
// Arbitrates icache refills and dcache accesses onto one memory channel,
// one outstanding transaction at a time, with a registered done pulse per side.
module ysyx_22041412_mem_arb
  import ysyx_22041412_mem_arb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 128
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_valid_i,
  output logic              i_ready_o,
  input  logic [ADDR_W-1:0] i_addr_i,
  output logic              i_done_o,
  output logic [DATA_W-1:0] i_rdata_o,
  input  logic              d_valid_i,
  output logic              d_ready_o,
  input  logic [ADDR_W-1:0] d_addr_i,
  input  logic              d_wen_i,
  input  logic [DATA_W-1:0] d_wdata_i,
  output logic              d_done_o,
  output logic [DATA_W-1:0] d_rdata_o,
  output logic              mem_valid_o,
  input  logic              mem_ready_i,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic              mem_wen_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic              mem_done_i,
  input  logic [DATA_W-1:0] mem_rdata_i
);

  arb_state_e        state_q, state_d;
  arb_owner_e        owner_q, owner_d;
  arb_owner_e        last_q, last_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              wen_q, wen_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              i_done_q, i_done_d, d_done_q, d_done_d;
  logic [DATA_W-1:0] i_rdata_q, i_rdata_d, d_rdata_q, d_rdata_d;
  logic              complete;
  logic [1:0]        gnt;

  ysyx_22041412_rr2 u_rr2 (
    .req_i  ({d_valid_i, i_valid_i}),
    .last_i (last_q),
    .gnt_o  (gnt)
  );

  // Ready is only offered while idle, so the handshake can only happen there.
  assign i_ready_o = (state_q == ARB_IDLE) && gnt[0];
  assign d_ready_o = (state_q == ARB_IDLE) && gnt[1];

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    last_d    = last_q;
    addr_d    = addr_q;
    wen_d     = wen_q;
    wdata_d   = wdata_q;
    i_rdata_d = i_rdata_q;
    d_rdata_d = d_rdata_q;
    i_done_d  = 1'b0;
    d_done_d  = 1'b0;
    complete  = 1'b0;
    case (state_q)
      ARB_IDLE: begin
        if (i_valid_i && i_ready_o) begin
          state_d = ARB_REQ;
          owner_d = OWNER_I;
          last_d  = OWNER_I;
          addr_d  = i_addr_i;
          wen_d   = 1'b0;
          wdata_d = '0;
        end else if (d_valid_i && d_ready_o) begin
          state_d = ARB_REQ;
          owner_d = OWNER_D;
          last_d  = OWNER_D;
          addr_d  = d_addr_i;
          wen_d   = d_wen_i;
          wdata_d = d_wdata_i;
        end
      end
      ARB_REQ: begin
        // A done arriving together with ready closes the transaction at once.
        if (mem_ready_i) begin
          if (mem_done_i) begin
            complete = 1'b1;
            state_d  = ARB_IDLE;
          end else begin
            state_d  = ARB_RESP;
          end
        end
      end
      ARB_RESP: begin
        if (mem_done_i) begin
          complete = 1'b1;
          state_d  = ARB_IDLE;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
    if (complete) begin
      if (owner_q == OWNER_I) begin
        i_done_d = 1'b1;
        if (!wen_q) i_rdata_d = mem_rdata_i;
      end else begin
        d_done_d = 1'b1;
        if (!wen_q) d_rdata_d = mem_rdata_i;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= ARB_IDLE;
      owner_q   <= OWNER_I;
      last_q    <= OWNER_D;
      addr_q    <= '0;
      wen_q     <= 1'b0;
      wdata_q   <= '0;
      i_done_q  <= 1'b0;
      d_done_q  <= 1'b0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      last_q    <= last_d;
      addr_q    <= addr_d;
      wen_q     <= wen_d;
      wdata_q   <= wdata_d;
      i_done_q  <= i_done_d;
      d_done_q  <= d_done_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
    end
  end

  assign mem_valid_o = (state_q == ARB_REQ);
  assign mem_addr_o  = addr_q;
  assign mem_wen_o   = wen_q;
  assign mem_wdata_o = wdata_q;
  assign i_done_o    = i_done_q;
  assign d_done_o    = d_done_q;
  assign i_rdata_o   = i_rdata_q;
  assign d_rdata_o   = d_rdata_q;

endmodule

// File: tb/tb_ysyx_22041412_mem_arb.sv
// Randomized scoreboard bench for the I/D memory arbiter with a transaction-level model.
module tb_ysyx_22041412_mem_arb;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         i_valid_i = 1'b0, d_valid_i = 1'b0, d_wen_i = 1'b0;
  logic [31:0]  i_addr_i = '0, d_addr_i = '0;
  logic [127:0] d_wdata_i = '0, mem_rdata_i = '0;
  logic         mem_ready_i = 1'b0, mem_done_i = 1'b0;
  logic         i_ready_o, i_done_o, d_ready_o, d_done_o, mem_valid_o, mem_wen_o;
  logic [127:0] i_rdata_o, d_rdata_o, mem_wdata_o;
  logic [31:0]  mem_addr_o;

  ysyx_22041412_mem_arb dut (
    .clk(clk), .rst(rst),
    .i_valid_i(i_valid_i), .i_ready_o(i_ready_o), .i_addr_i(i_addr_i),
    .i_done_o(i_done_o), .i_rdata_o(i_rdata_o),
    .d_valid_i(d_valid_i), .d_ready_o(d_ready_o), .d_addr_i(d_addr_i),
    .d_wen_i(d_wen_i), .d_wdata_i(d_wdata_i), .d_done_o(d_done_o), .d_rdata_o(d_rdata_o),
    .mem_valid_o(mem_valid_o), .mem_ready_i(mem_ready_i), .mem_addr_o(mem_addr_o),
    .mem_wen_o(mem_wen_o), .mem_wdata_o(mem_wdata_o),
    .mem_done_i(mem_done_i), .mem_rdata_i(mem_rdata_i)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [31:0] addr; logic wen; logic [127:0] wdata; } req_t;
  typedef struct packed { int cyc; logic side; logic wr; logic [127:0] rdata; } done_t;

  int checks = 0, errs = 0;

  // Transaction-level model: who owns the bus, whether memory took it,
  // the round-robin memory, and each side's last read line.
  bit           armed = 0, busy = 0, acc = 0, last_d_m = 1, just_rst = 0;
  bit           hs_i = 0, hs_d = 0, cur_side = 0, cur_wen = 0;
  logic [31:0]  cur_addr = '0;
  logic [127:0] cur_wdata = '0, mi = '0, md = '0;
  int           cyc = 0;
  req_t         req_q[$];
  done_t        done_q[$];

  task automatic chk1(input string nm, input logic a, input logic e);
    checks++;
    if (a !== e) begin errs++; $display("FAIL %s: got %b expected %b (cycle %0d)", nm, a, e, cyc); end
  endtask

  task automatic chkw(input string nm, input logic [127:0] a, input logic [127:0] e);
    checks++;
    if (a !== e) begin errs++; $display("FAIL %s: got %h expected %h (cycle %0d)", nm, a, e, cyc); end
  endtask

  task automatic finish_txn();
    done_q.push_back('{cyc: cyc + 1, side: cur_side, wr: cur_wen, rdata: mem_rdata_i});
    busy = 0;
    acc  = 0;
  endtask

  // Monitor: check the current cycle, then advance the model using the
  // inputs that the coming rising edge will sample.
  always @(negedge clk) begin
    bit gi, gd;
    done_t e;
    req_t r;
    gi = i_valid_i && (!d_valid_i || last_d_m);
    gd = d_valid_i && (!i_valid_i || !last_d_m);
    if (armed) begin
      chk1("mem_valid", mem_valid_o, busy && !acc);
      chk1("i_ready", i_ready_o, !busy && gi);
      chk1("d_ready", d_ready_o, !busy && gd);
      if (busy && !acc) begin
        chkw("mem_addr_hold", 128'(mem_addr_o), 128'(cur_addr));
        chk1("mem_wen_hold", mem_wen_o, cur_wen);
        if (cur_wen) chkw("mem_wdata_hold", mem_wdata_o, cur_wdata);
      end
      if (just_rst) begin
        chkw("rst_mem_addr", 128'(mem_addr_o), 128'd0);
        chk1("rst_mem_wen", mem_wen_o, 1'b0);
        chkw("rst_mem_wdata", mem_wdata_o, 128'd0);
      end
      if (done_q.size() != 0 && done_q[0].cyc == cyc) begin
        e = done_q.pop_front();
        if (!e.wr) begin
          if (e.side) md = e.rdata; else mi = e.rdata;
        end
        chk1("i_done", i_done_o, !e.side);
        chk1("d_done", d_done_o, e.side);
      end else begin
        chk1("i_done_idle", i_done_o, 1'b0);
        chk1("d_done_idle", d_done_o, 1'b0);
      end
      chkw("i_rdata", i_rdata_o, mi);
      chkw("d_rdata", d_rdata_o, md);
    end
    hs_i = 0; hs_d = 0; just_rst = 0;
    if (!rst) begin
      busy = 0; acc = 0; last_d_m = 1; mi = '0; md = '0;
      req_q.delete(); done_q.delete();
      just_rst = 1; armed = 1;
    end else if (armed) begin
      if (busy) begin
        if (!acc && mem_ready_i) begin
          if (req_q.size() == 0) begin
            checks++; errs++; $display("FAIL req_q: memory accepted with no issued request (cycle %0d)", cyc);
          end else begin
            r = req_q.pop_front();
            chkw("mem_addr", 128'(mem_addr_o), 128'(r.addr));
            chk1("mem_wen", mem_wen_o, r.wen);
            if (r.wen) chkw("mem_wdata", mem_wdata_o, r.wdata);
          end
          if (mem_done_i) finish_txn(); else acc = 1;
        end else if (acc && mem_done_i) finish_txn();
      end else if (gi) begin
        hs_i = 1; busy = 1; acc = 0; cur_side = 0; last_d_m = 0;
        cur_addr = i_addr_i; cur_wen = 0; cur_wdata = '0;
        req_q.push_back('{addr: i_addr_i, wen: 1'b0, wdata: 128'd0});
      end else if (gd) begin
        hs_d = 1; busy = 1; acc = 0; cur_side = 1; last_d_m = 1;
        cur_addr = d_addr_i; cur_wen = d_wen_i; cur_wdata = d_wdata_i;
        req_q.push_back('{addr: d_addr_i, wen: d_wen_i, wdata: d_wdata_i});
      end
    end
    cyc++;
  end

  // Memory responder and requester stimulus
  int ph = 0, dly = 0, dd = 0, rdy_cfg = -1, done_cfg = -1;
  bit resp_en = 0, junk_en = 0, rand_req = 0, rdata_fix = 0;

  function automatic logic [127:0] rdat();
    if (rdata_fix) return 128'h13;
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic resp_step();
    if (!resp_en) return;
    mem_ready_i = 0;
    mem_done_i  = 0;
    if (ph == 2) begin
      dd--;
      if (dd <= 0) begin mem_done_i = 1; mem_rdata_i = rdat(); ph = 0; end
    end else if (ph == 0) begin
      if (mem_valid_o === 1'b1) begin
        dly = (rdy_cfg >= 0) ? rdy_cfg : int'($urandom_range(0, 3));
        ph  = 1;
      end else mem_done_i = junk_en && ($urandom_range(0, 1) == 1);
    end
    if (ph == 1) begin
      if (dly == 0) begin
        mem_ready_i = 1;
        mem_rdata_i = rdat();
        dd = (done_cfg >= 0) ? done_cfg : int'($urandom_range(0, 3));
        if (dd == 0) begin mem_done_i = 1; ph = 0; end else ph = 2;
      end else begin
        dly--;
        mem_done_i = junk_en && ($urandom_range(0, 1) == 1);
      end
    end
  endtask

  task automatic req_step();
    if (!i_valid_i && $urandom_range(0, 3) == 0) begin
      i_valid_i = 1; i_addr_i = $urandom;
    end else if (i_valid_i && $urandom_range(0, 15) == 0) i_valid_i = 0;
    if (!d_valid_i && $urandom_range(0, 3) == 0) begin
      d_valid_i = 1; d_addr_i = $urandom; d_wen_i = $urandom_range(0, 1) == 1;
      d_wdata_i = {$urandom, $urandom, $urandom, $urandom};
    end else if (d_valid_i && $urandom_range(0, 15) == 0) d_valid_i = 0;
  endtask

  task automatic tick();
    @(posedge clk); #1;
    if (hs_i) i_valid_i = 0;
    if (hs_d) d_valid_i = 0;
    if (rand_req) req_step();
    resp_step();
  endtask

  task automatic wait_quiet(input int n);
    int k = 0;
    while ((i_valid_i || d_valid_i || busy || ph != 0 || done_q.size() != 0) && k < n) begin
      tick(); k++;
    end
    checks++;
    if (k >= n) begin errs++; $display("FAIL wait_quiet: still busy after %0d cycles (cycle %0d)", n, cyc); end
    tick(); tick();
  endtask

  task automatic do_reset();
    rst = 0; resp_en = 0; ph = 0; mem_ready_i = 0; mem_done_i = 0;
    tick(); tick();
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset();
    rst = 1; resp_en = 1;
    tick();

    // Minimum-latency icache refill with known line data
    rdy_cfg = 0; done_cfg = 0; rdata_fix = 1;
    i_valid_i = 1; i_addr_i = 32'h8000_0000;
    wait_quiet(20);
    rdata_fix = 0;

    // Tie on the first cycle out of reset, then a later tie
    rdy_cfg = 1; done_cfg = 1;
    do_reset();
    rst = 1; resp_en = 1;
    i_valid_i = 1; i_addr_i = 32'h8000_0010;
    d_valid_i = 1; d_addr_i = 32'h8000_1000; d_wen_i = 0;
    wait_quiet(40);
    i_valid_i = 1; i_addr_i = 32'h8000_0020;
    d_valid_i = 1; d_addr_i = 32'h8000_1010; d_wen_i = 0;
    wait_quiet(40);

    // Write with ready held off, done two cycles after acceptance
    rdy_cfg = 3; done_cfg = 2;
    d_valid_i = 1; d_addr_i = 32'h8000_2000; d_wen_i = 1;
    d_wdata_i = 128'hDEADBEEF_CAFEF00D_01234567_89ABCDEF;
    wait_quiet(40);

    // Stray done in IDLE and in REQ without ready
    resp_en = 0; mem_done_i = 1; tick(); mem_done_i = 0; resp_en = 1; tick();
    junk_en = 1; rdy_cfg = 3; done_cfg = 1;
    i_valid_i = 1; i_addr_i = 32'h8000_0040;
    wait_quiet(40);

    // I request withdrawn while D owns the bus
    d_valid_i = 1; d_addr_i = 32'h8000_3000; d_wen_i = 0;
    tick(); tick();
    i_valid_i = 1; i_addr_i = 32'h8000_0080;
    tick();
    i_valid_i = 0;
    wait_quiet(40);

    // Reset while waiting in RESP, then a late done
    junk_en = 0; rdy_cfg = 0; done_cfg = 4;
    i_valid_i = 1; i_addr_i = 32'h8000_0100;
    tick(); tick();
    rst = 0; resp_en = 0; ph = 0; mem_ready_i = 0; mem_done_i = 0;
    tick();
    rst = 1;
    mem_done_i = 1; tick(); tick(); mem_done_i = 0;
    resp_en = 1;
    wait_quiet(20);

    // Random traffic
    junk_en = 1; rdy_cfg = -1; done_cfg = -1; rand_req = 1;
    repeat (1500) tick();
    rand_req = 0;
    wait_quiet(100);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errs);
    $finish;
  end

endmodule
